key_bounce_gen: RTL and testbench

Synthesizable bouncing-key generator: it drives an active-low key line with a pseudo-random mechanical bounce burst on every press and release command. It is the transmit side of the key-input path. It lets on-FPGA self-test and closed-loop benches exercise the key debouncer with realistic, reproducible contact chatter. It sits between a command source (test sequencer or CPU register) and the key_n input of the debounce logic.

---
 rtl/key_pkg.sv | 19 +
 rtl/key_bounce_gen_if.sv | 21 ++
 rtl/lfsr16.sv | 31 +++
 rtl/key_bounce_gen.sv | 102 ++++++++++
 tb/tb_key_bounce_gen.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key-bounce stimulus blocks.
package key_pkg;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        BOUNCE_DN = 2'd1,
        HELD      = 2'd2,
        BOUNCE_UP = 2'd3
    } key_state_e;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/key_bounce_gen_if.sv
// Command handshake and emulated key line between sequencer and bounce generator.
interface key_bounce_gen_if;

    logic cmd_valid;
    logic cmd_press;
    logic cmd_ready;
    logic key_n;
    logic busy;
    logic settled_pulse;

    modport master (
        output cmd_valid, cmd_press,
        input  cmd_ready, key_n, busy, settled_pulse
    );

    modport slave (
        input  cmd_valid, cmd_press,
        output cmd_ready, key_n, busy, settled_pulse
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, reloaded with SEED on reset.
module lfsr16
    import key_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next value of the shift register.
    always_comb begin
        state_d = lfsr_next(state_q);
    end

    // State register; advances every cycle outside reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/key_bounce_gen.sv
// Emulated mechanical key: pseudo-random contact chatter on each press/release.
module key_bounce_gen
    import key_pkg::*;
#(
    parameter int unsigned BOUNCE_CYC = 200000,
    parameter int unsigned WIDTH      = 18,
    parameter int unsigned GAP_W      = 8,
    parameter logic [15:0] SEED       = LFSR_SEED_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    key_bounce_gen_if.slave bus
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(BOUNCE_CYC - 1);

    key_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             key_q, key_d;
    logic             settled_q, settled_d;
    logic [15:0]      lfsr;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    // Only the low GAP_W bits feed the gap reload.
    if (GAP_W < 16) begin : g_unused_lfsr
        logic unused_lfsr_hi;
        assign unused_lfsr_hi = ^lfsr[15:GAP_W];
    end

    // Next-state, counters and key level.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        key_d     = key_q;
        settled_d = 1'b0;
        case (state_q)
            UP: begin
                if (bus.cmd_valid && bus.cmd_press) begin
                    state_d = BOUNCE_DN;
                    key_d   = ~key_q;
                    cnt_d   = '0;
                    gap_d   = lfsr[GAP_W-1:0];
                end
            end
            HELD: begin
                if (bus.cmd_valid && !bus.cmd_press) begin
                    state_d = BOUNCE_UP;
                    key_d   = ~key_q;
                    cnt_d   = '0;
                    gap_d   = lfsr[GAP_W-1:0];
                end
            end
            BOUNCE_DN, BOUNCE_UP: begin
                cnt_d = cnt_q + WIDTH'(1);
                if (cnt_d == CNT_LAST) begin
                    // Forcing wins over any coincident gap expiry.
                    key_d     = (state_q == BOUNCE_UP);
                    state_d   = (state_q == BOUNCE_UP) ? UP : HELD;
                    settled_d = 1'b1;
                end else if (gap_q == '0) begin
                    key_d = ~key_q;
                    gap_d = lfsr[GAP_W-1:0];
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = UP;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= UP;
            cnt_q     <= '0;
            gap_q     <= '0;
            key_q     <= 1'b1;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            key_q     <= key_d;
            settled_q <= settled_d;
        end
    end

    assign bus.cmd_ready     = (state_q == UP) || (state_q == HELD);
    assign bus.busy          = (state_q == BOUNCE_DN) || (state_q == BOUNCE_UP);
    assign bus.key_n         = key_q;
    assign bus.settled_pulse = settled_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench for key_bounce_gen with BOUNCE_CYC=16, GAP_W=2, SEED=ACE1.
module tb_key_bounce_gen;

    logic clk;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    // key_n after edges 1..16 of a press accepted on the first edge after reset.
    logic [1:16] exp_dn;

    key_bounce_gen_if bus();

    key_bounce_gen #(
        .BOUNCE_CYC (16),
        .WIDTH      (5),
        .GAP_W      (2),
        .SEED       (16'hACE1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_press = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Press presented right after reset release; checks ncyc cycles of the burst.
    task automatic press_burst(input string pfx, input int ncyc);
        bus.cmd_valid = 1'b1;
        bus.cmd_press = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            step();
            if (k == 1) bus.cmd_valid = 1'b0;
            chk($sformatf("%s_key_%0d", pfx, k),     16'(bus.key_n),         16'(exp_dn[k]));
            chk($sformatf("%s_busy_%0d", pfx, k),    16'(bus.busy),          16'(k < 16));
            chk($sformatf("%s_settled_%0d", pfx, k), 16'(bus.settled_pulse), 16'(k == 16));
            chk($sformatf("%s_ready_%0d", pfx, k),   16'(bus.cmd_ready),     16'(k == 16));
        end
    endtask

    initial begin
        int   last_t;
        logic prev_k;

        exp_dn = 16'h2E76;

        // Reset values
        do_reset();
        chk("rst_key",     16'(bus.key_n),         16'd1);
        chk("rst_ready",   16'(bus.cmd_ready),     16'd1);
        chk("rst_busy",    16'(bus.busy),          16'd0);
        chk("rst_settled", 16'(bus.settled_pulse), 16'd0);

        // Press burst, exact waveform and settle timing
        press_burst("dn", 16);

        // Redundant press while HELD
        bus.cmd_valid = 1'b1;
        bus.cmd_press = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        chk("red_key",     16'(bus.key_n),         16'd0);
        chk("red_busy",    16'(bus.busy),          16'd0);
        chk("red_settled", 16'(bus.settled_pulse), 16'd0);
        chk("red_ready",   16'(bus.cmd_ready),     16'd1);
        step();
        chk("red_key2",    16'(bus.key_n),         16'd0);
        chk("red_busy2",   16'(bus.busy),          16'd0);

        // Release then press held on cmd_valid, back-to-back
        bus.cmd_valid = 1'b1;
        bus.cmd_press = 1'b0;
        prev_k = bus.key_n;
        last_t = 0;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 1) begin
                bus.cmd_press = 1'b1;
                chk("rel_first_edge", 16'(bus.key_n), 16'd1);
            end
            if (k <= 16 && bus.key_n !== prev_k) begin
                chk($sformatf("rel_gap_%0d", k), 16'((k - last_t) <= 4), 16'd1);
                last_t = k;
                prev_k = bus.key_n;
            end
            if (k < 16) begin
                chk($sformatf("rel_busy_%0d", k),    16'(bus.busy),          16'd1);
                chk($sformatf("rel_ready_%0d", k),   16'(bus.cmd_ready),     16'd0);
                chk($sformatf("rel_settled_%0d", k), 16'(bus.settled_pulse), 16'd0);
            end else if (k == 16) begin
                chk("rel_final_key", 16'(bus.key_n),         16'd1);
                chk("rel_settled",   16'(bus.settled_pulse), 16'd1);
                chk("rel_ready",     16'(bus.cmd_ready),     16'd1);
                chk("rel_busy_end",  16'(bus.busy),          16'd0);
            end else begin
                bus.cmd_valid = 1'b0;
                chk("b2b_press_key",     16'(bus.key_n),         16'd0);
                chk("b2b_press_busy",    16'(bus.busy),          16'd1);
                chk("b2b_press_settled", 16'(bus.settled_pulse), 16'd0);
            end
        end

        // Reset mid-burst, then the same press must reproduce the first burst
        do_reset();
        press_burst("mid", 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_key",     16'(bus.key_n),         16'd1);
        chk("mid_rst_busy",    16'(bus.busy),          16'd0);
        chk("mid_rst_ready",   16'(bus.cmd_ready),     16'd1);
        chk("mid_rst_settled", 16'(bus.settled_pulse), 16'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        press_burst("rep", 16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
